// File: rtl/tone_player.sv
// ============================================================================
// Module   : tone_player
// Purpose  : Plays a latched-prescale square-wave tone for a fixed duration,
//            then enforces a silent gap. Optional macro: TONE_PLAYER_DECAY_EN
//            (steps the amplitude down by 6 dB per elapsed quarter of the tone).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tone_player #(
   parameter int          DURATION_CYCLES = 2_500_000,
   parameter int          GAP_CYCLES      = 250_000,
   parameter logic [15:0] AMPLITUDE       = 16'h2000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        request,
   input  logic [9:0]  pre_scale_value,
   output logic        busy,
   output logic        tone_on,
   output logic        done,
   output logic [7:0]  phase,
   output logic [15:0] sample
);

   localparam int c_DUR_W = $clog2(DURATION_CYCLES) + 1;
   localparam int c_GAP_W = $clog2(GAP_CYCLES) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t               r_state;
   logic [9:0]           r_preScale;
   logic [9:0]           r_div;
   logic [c_DUR_W-1:0]   r_dur;
   logic [c_GAP_W-1:0]   r_gap;

   logic                 w_start;
   logic                 w_phaseAdv;
   logic [7:0]           w_phaseNext;
   logic [c_DUR_W-1:0]   w_durDec;
   logic [1:0]           w_quarter;

   // A request is honoured only in IDLE or PLAY and only with a real tone.
   assign w_start     = request && (pre_scale_value != 10'd0) &&
                        ((r_state == S_IDLE) || (r_state == S_PLAY));
   assign w_phaseAdv  = (r_div == (r_preScale - 10'd1));
   assign w_phaseNext = w_phaseAdv ? (phase + 8'd1) : phase;
   assign w_durDec    = r_dur - c_DUR_W'(1);

`ifdef TONE_PLAYER_DECAY_EN
   localparam int c_QTR = DURATION_CYCLES / 4;
   localparam int c_T1  = DURATION_CYCLES - 1 - c_QTR;
   localparam int c_T2  = DURATION_CYCLES - 1 - 2 * c_QTR;
   localparam int c_T3  = DURATION_CYCLES - 1 - 3 * c_QTR;

   // Remaining-count thresholds mark the quarter boundaries; the last absorbs the remainder.
   always_comb begin
      w_quarter = 2'd0;
      if (w_durDec <= c_DUR_W'(c_T1)) w_quarter = 2'd1;
      if (w_durDec <= c_DUR_W'(c_T2)) w_quarter = 2'd2;
      if (w_durDec <= c_DUR_W'(c_T3)) w_quarter = 2'd3;
   end
`else
   assign w_quarter = 2'd0;
`endif

   function automatic logic [15:0] levelFor(input logic negHalf, input logic [1:0] q);
      logic [15:0] mag;
      mag = 16'($signed(AMPLITUDE) >>> q);
      return negHalf ? (16'd0 - mag) : mag;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_preScale <= 10'd0;
         r_div      <= 10'd0;
         r_dur      <= '0;
         r_gap      <= '0;
         busy       <= 1'b0;
         tone_on    <= 1'b0;
         done       <= 1'b0;
         phase      <= 8'd0;
         sample     <= 16'd0;
      end else begin
         done <= 1'b0;
         if (w_start) begin
            // Fresh start or retrigger; a retrigger beats the end-of-tone transition.
            r_state    <= S_PLAY;
            r_preScale <= pre_scale_value;
            r_div      <= 10'd0;
            r_dur      <= c_DUR_W'(DURATION_CYCLES - 1);
            busy       <= 1'b1;
            tone_on    <= 1'b1;
            phase      <= 8'd0;
            sample     <= levelFor(1'b0, 2'd0);
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_state <= S_IDLE;
               end
               S_PLAY: begin
                  if (r_dur == '0) begin
                     r_state <= S_GAP;
                     r_gap   <= c_GAP_W'(GAP_CYCLES - 1);
                     done    <= 1'b1;
                     tone_on <= 1'b0;
                     sample  <= 16'd0;
                  end else begin
                     r_dur  <= w_durDec;
                     r_div  <= w_phaseAdv ? 10'd0 : (r_div + 10'd1);
                     phase  <= w_phaseNext;
                     sample <= levelFor(w_phaseNext[7], w_quarter);
                  end
               end
               S_GAP: begin
                  if (r_gap == '0) begin
                     r_state <= S_IDLE;
                     busy    <= 1'b0;
                  end else begin
                     r_gap <= r_gap - c_GAP_W'(1);
                  end
               end
               default: begin
                  r_state <= S_IDLE;
                  busy    <= 1'b0;
                  tone_on <= 1'b0;
                  sample  <= 16'd0;
               end
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_tone_player.sv
// ============================================================================
// Module   : tb_tone_player
// Purpose  : Directed bench for tone_player; two instances (100- and 300-cycle
//            tones) checked every cycle against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tone_player;

   localparam int GAP = 10;
`ifdef TONE_PLAYER_DECAY_EN
   localparam bit DECAY = 1'b1;
`else
   localparam bit DECAY = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        reqA, reqB;
   logic [9:0]  psA, psB;
   logic        busyA, toneA, doneA, busyB, toneB, doneB;
   logic [7:0]  phaseA, phaseB;
   logic [15:0] sampleA, sampleB;

   int passCnt  = 0;
   int totalCnt = 0;
   int cyc      = 0;

   // Reference model: 0=idle 1=play 2=gap; mT = cycles elapsed since (re)start.
   int mMode[2];
   int mT[2];
   int mPs[2];
   int mGap[2];
   int mPhase[2];
   bit mDone[2];
   int durOf[2] = '{100, 300};

   always #5 clk = ~clk;

   tone_player #(.DURATION_CYCLES(100), .GAP_CYCLES(GAP), .AMPLITUDE(16'h2000)) dutA (
      .clk(clk), .reset(reset), .request(reqA), .pre_scale_value(psA),
      .busy(busyA), .tone_on(toneA), .done(doneA), .phase(phaseA), .sample(sampleA));

   tone_player #(.DURATION_CYCLES(300), .GAP_CYCLES(GAP), .AMPLITUDE(16'h2000)) dutB (
      .clk(clk), .reset(reset), .request(reqB), .pre_scale_value(psB),
      .busy(busyB), .tone_on(toneB), .done(doneB), .phase(phaseB), .sample(sampleB));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      totalCnt++;
      if (act === exp) passCnt++;
      else $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic int expSample(input int i);
      int q;
      int mag;
      if (mMode[i] != 1) return 0;
      q = 0;
      if (DECAY) begin
         q = mT[i] / (durOf[i] / 4);
         if (q > 3) q = 3;
      end
      mag = 'h2000 >> q;
      return ((mPhase[i] & 128) != 0) ? (65536 - mag) : mag;
   endfunction

   task automatic modelEdge(input int i, input bit rq, input int pv);
      mDone[i] = 1'b0;
      if (reset) begin
         mMode[i]  = 0;
         mPhase[i] = 0;
         return;
      end
      case (mMode[i])
         0: if (rq && pv != 0) begin
               mMode[i] = 1; mPs[i] = pv; mT[i] = 0; mPhase[i] = 0;
            end
         1: if (rq && pv != 0) begin
               mPs[i] = pv; mT[i] = 0; mPhase[i] = 0;
            end else if (mT[i] == durOf[i] - 1) begin
               mMode[i] = 2; mDone[i] = 1'b1; mGap[i] = GAP;
            end else begin
               mT[i]++;
               mPhase[i] = (mT[i] / mPs[i]) % 256;
            end
         default: begin
            mGap[i]--;
            if (mGap[i] == 0) mMode[i] = 0;
         end
      endcase
   endtask

   task automatic cmp(input string tag, input int i, input logic b, input logic t,
                      input logic d, input logic [7:0] p, input logic [15:0] s);
      chk({tag, ".busy"},    b, (mMode[i] != 0) ? 1 : 0);
      chk({tag, ".tone_on"}, t, (mMode[i] == 1) ? 1 : 0);
      chk({tag, ".done"},    d, mDone[i]);
      chk({tag, ".phase"},   p, mPhase[i]);
      chk({tag, ".sample"},  s, expSample(i));
   endtask

   task automatic step();
      @(posedge clk);
      modelEdge(0, reqA, int'(psA));
      modelEdge(1, reqB, int'(psB));
      #1;
      cyc++;
      cmp("A", 0, busyA, toneA, doneA, phaseA, sampleA);
      cmp("B", 1, busyB, toneB, doneB, phaseB, sampleB);
   endtask

   initial begin
      reset = 1'b1; reqA = 1'b0; reqB = 1'b0; psA = 10'd0; psB = 10'd0;
      step(); step();
      chk("lit.reset.busy", busyA, 0);
      chk("lit.reset.sample", sampleA, 0);
      reset = 1'b0;
      step();

      // Reset mid-PLAY: immediate return to IDLE with no done pulse.
      reqA = 1'b1; psA = 10'd2; reqB = 1'b1; psB = 10'd1;
      step();
      reqA = 1'b0; reqB = 1'b0;
      for (int k = 0; k < 20; k++) step();
      chk("lit.midreset.phaseA.before", phaseA, 10);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("lit.midreset.busy",   busyA,   0);
      chk("lit.midreset.tone",   toneA,   0);
      chk("lit.midreset.done",   doneA,   0);
      chk("lit.midreset.phase",  phaseA,  0);
      chk("lit.midreset.sample", sampleA, 0);
      chk("lit.midreset.busyB",  busyB,   0);
      step();
      chk("lit.midreset.done.after", doneA, 0);

      // ps=3 tone, with ignored requests during GAP and ps=0 in IDLE.
      reqA = 1'b1; psA = 10'd3;
      step();
      chk("lit.ps3.busy0",   busyA,   1);
      chk("lit.ps3.tone0",   toneA,   1);
      chk("lit.ps3.sample0", sampleA, 16'h2000);
      for (int k = 1; k <= 112; k++) begin
         reqA = (k == 105) || (k == 111);
         psA  = (k == 111) ? 10'd0 : ((k == 105) ? 10'd4 : 10'd7);
         step();
         if (k == 2)   chk("lit.ps3.phase@2",   phaseA, 0);
         if (k == 3)   chk("lit.ps3.phase@3",   phaseA, 1);
         if (k == 99)  chk("lit.ps3.phase@99",  phaseA, 33);
         if (k == 99)  chk("lit.ps3.done@99",   doneA,  0);
         if (k == 100) chk("lit.ps3.done@100",  doneA,  1);
         if (k == 100) chk("lit.ps3.tone@100",  toneA,  0);
         if (k == 101) chk("lit.ps3.done@101",  doneA,  0);
         if (k == 105) chk("lit.gapreq.busy",   busyA,  1);
         if (k == 105) chk("lit.gapreq.phase",  phaseA, 33);
         if (k == 109) chk("lit.ps3.busy@109",  busyA,  1);
         if (k == 110) chk("lit.ps3.busy@110",  busyA,  0);
         if (k == 111) chk("lit.ps0req.busy",   busyA,  0);
      end
      reqA = 1'b0;

      // Retrigger at cycle 50 with ps=5; ps=0 request in PLAY ignored.
      reqA = 1'b1; psA = 10'd2;
      step();
      for (int k = 1; k <= 161; k++) begin
         reqA = (k == 50) || (k == 60);
         psA  = (k == 50) ? 10'd5 : ((k == 60) ? 10'd0 : 10'd9);
         step();
         if (k == 49)  chk("lit.retrig.phase@49",  phaseA, 24);
         if (k == 50)  chk("lit.retrig.phase@50",  phaseA, 0);
         if (k == 55)  chk("lit.retrig.phase@55",  phaseA, 1);
         if (k == 60)  chk("lit.retrig.phase@60",  phaseA, 2);
         if (k == 100) chk("lit.retrig.done@100",  doneA,  0);
         if (k == 149) chk("lit.retrig.phase@149", phaseA, 19);
         if (k == 150) chk("lit.retrig.done@150",  doneA,  1);
         if (k == 160) chk("lit.retrig.busy@160",  busyA,  0);
      end
      reqA = 1'b0;

      // Retrigger on the final PLAY cycle suppresses done and GAP.
      reqA = 1'b1; psA = 10'd1;
      step();
      for (int k = 1; k <= 211; k++) begin
         reqA = (k == 100);
         psA  = (k == 100) ? 10'd1 : 10'd3;
         step();
         if (k == 99)  chk("lit.edge.phase@99",  phaseA, 99);
         if (k == 100) chk("lit.edge.done@100",  doneA,  0);
         if (k == 100) chk("lit.edge.tone@100",  toneA,  1);
         if (k == 100) chk("lit.edge.phase@100", phaseA, 0);
         if (k == 199) chk("lit.edge.done@199",  doneA,  0);
         if (k == 200) chk("lit.edge.done@200",  doneA,  1);
         if (k == 210) chk("lit.edge.busy@210",  busyA,  0);
      end
      reqA = 1'b0;

      // ps=1 on the 300-cycle instance: half-period sign flip and phase wrap.
      reqB = 1'b1; psB = 10'd1;
      step();
      reqB = 1'b0;
      for (int k = 1; k <= 310; k++) begin
         step();
         if (k == 127) chk("lit.wrap.phase@127",  phaseB, 127);
         if (k == 127) chk("lit.wrap.sample@127", sampleB, DECAY ? 16'h1000 : 16'h2000);
         if (k == 128) chk("lit.wrap.phase@128",  phaseB, 128);
         if (k == 128) chk("lit.wrap.sample@128", sampleB, DECAY ? 16'hF000 : 16'hE000);
         if (k == 255) chk("lit.wrap.phase@255",  phaseB, 255);
         if (k == 256) chk("lit.wrap.phase@256",  phaseB, 0);
         if (k == 300) chk("lit.wrap.done@300",   doneB,  1);
         if (k == 310) chk("lit.wrap.busy@310",   busyB,  0);
      end

      // Amplitude per quarter with phase pinned at 0 (positive half).
      reqA = 1'b1; psA = 10'd1023;
      step();
      reqA = 1'b0;
      chk("lit.amp.sample@0", sampleA, 16'h2000);
      for (int k = 1; k <= 111; k++) begin
         step();
         if (k == 24) chk("lit.amp.sample@24", sampleA, 16'h2000);
         if (k == 25) chk("lit.amp.sample@25", sampleA, DECAY ? 16'h1000 : 16'h2000);
         if (k == 49) chk("lit.amp.sample@49", sampleA, DECAY ? 16'h1000 : 16'h2000);
         if (k == 50) chk("lit.amp.sample@50", sampleA, DECAY ? 16'h0800 : 16'h2000);
         if (k == 74) chk("lit.amp.sample@74", sampleA, DECAY ? 16'h0800 : 16'h2000);
         if (k == 75) chk("lit.amp.sample@75", sampleA, DECAY ? 16'h0400 : 16'h2000);
         if (k == 99) chk("lit.amp.sample@99", sampleA, DECAY ? 16'h0400 : 16'h2000);
      end

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule

`default_nettype wire
